// File: rtl/snd_dac_mix.sv
// snd_dac_mix: multi-channel PCM mixer with volume ramping, feeding a PDM DAC.
//
// Samples CHANNELS signed PCM inputs on every falling M2 edge. Each channel's
// gain ramps one step per sample toward its target, which suppresses zipper
// noise. The channels are multiply-accumulated through one shared multiplier,
// saturated to PCM_W bits, and then drive a delta-sigma modulator clocked at clk.
//
// Ports:
//   clk         system clock (100 MHz)
//   rst         synchronous active-high reset
//   m2          console M2, asynchronous to clk
//   pcm_in      packed signed samples, channel k = [k*PCM_W +: PCM_W]
//   volume      packed target volumes, channel k = [k*VOL_W +: VOL_W]
//   mute        forces every target volume to 0 (gains still ramp down)
//   pdm_out     PDM bitstream
//   sample_stb  one-cycle pulse when a new mixed level is committed
//   clip        last committed sample saturated (held until next commit)
//   overrun     sticky: strobe arrived while mixer busy (cleared by rst)
//
// Build option: define SND_DAC_ORDER2_EN to replace the first-order modulator
// with a second-order error-feedback modulator.
module snd_dac_mix #(
    parameter int CHANNELS = 2,
    parameter int PCM_W    = 16,
    parameter int VOL_W    = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      m2,
    input  logic [CHANNELS*PCM_W-1:0] pcm_in,
    input  logic [CHANNELS*VOL_W-1:0] volume,
    input  logic                      mute,
    output logic                      pdm_out,
    output logic                      sample_stb,
    output logic                      clip,
    output logic                      overrun
);

    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PROD_W = PCM_W + VOL_W + 1;
    localparam int SUM_W  = PROD_W + $clog2(CHANNELS);
    localparam logic [CH_W-1:0]         LAST_CH = CH_W'(CHANNELS - 1);
    localparam logic signed [SUM_W-1:0] SAT_HI  = SUM_W'((2 ** (PCM_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_LO  = ~SAT_HI;
    localparam logic [PCM_W-1:0]        MIDSCALE = {1'b1, {(PCM_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_SAT
    } state_t;

    state_t                   state_q, state_d;
    logic [2:0]               sync_q, sync_d;
    logic                     strobe;
    logic signed [PCM_W-1:0]  snap_q [CHANNELS];
    logic signed [PCM_W-1:0]  snap_d [CHANNELS];
    logic [VOL_W-1:0]         vol_q  [CHANNELS];
    logic [VOL_W-1:0]         vol_d  [CHANNELS];
    logic [VOL_W-1:0]         tgt    [CHANNELS];
    logic [CH_W-1:0]          ch_q, ch_d;
    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic [PCM_W-1:0]         level_q, level_d;
    logic                     sample_stb_q, sample_stb_d;
    logic                     clip_q, clip_d;
    logic                     overrun_q, overrun_d;
    logic                     pdm_q, pdm_d;
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  scaled;
    logic signed [PCM_W-1:0]  clamped;
    logic                     sat_hit;

    // sync_q[2] is the oldest sample; a 1->0 step is a falling M2 edge.
    assign sync_d = {sync_q[1:0], m2};
    assign strobe = (sync_q[2:1] == 2'b10);

    always_comb begin
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            tgt[k] = mute ? '0 : volume[k*VOL_W +: VOL_W];
        end
    end

    // Shared multiplier: volume is zero-extended to make it a non-negative signed operand.
    assign prod = PROD_W'(snap_q[ch_q]) * PROD_W'($signed({1'b0, vol_q[ch_q]}));

    always_comb begin
        scaled  = sum_q >>> VOL_W;
        sat_hit = 1'b0;
        clamped = scaled[PCM_W-1:0];
        if (scaled > SAT_HI) begin
            clamped = {1'b0, {(PCM_W-1){1'b1}}};
            sat_hit = 1'b1;
        end else if (scaled < SAT_LO) begin
            clamped = {1'b1, {(PCM_W-1){1'b0}}};
            sat_hit = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        sum_d        = sum_q;
        level_d      = level_q;
        clip_d       = clip_q;
        sample_stb_d = 1'b0;
        overrun_d    = overrun_q;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            snap_d[k] = snap_q[k];
            vol_d[k]  = vol_q[k];
        end

        if (strobe && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    for (int unsigned k = 0; k < CHANNELS; k++) begin
                        snap_d[k] = pcm_in[k*PCM_W +: PCM_W];
                        if (vol_q[k] < tgt[k]) begin
                            vol_d[k] = vol_q[k] + 1'b1;
                        end else if (vol_q[k] > tgt[k]) begin
                            vol_d[k] = vol_q[k] - 1'b1;
                        end
                    end
                    ch_d    = '0;
                    sum_d   = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                sum_d = sum_q + SUM_W'(prod);
                if (ch_q == LAST_CH) begin
                    state_d = ST_SAT;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            ST_SAT: begin
                level_d      = {~clamped[PCM_W-1], clamped[PCM_W-2:0]};
                clip_d       = sat_hit;
                sample_stb_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sync_q       <= '0;
            ch_q         <= '0;
            sum_q        <= '0;
            level_q      <= MIDSCALE;
            sample_stb_q <= 1'b0;
            clip_q       <= 1'b0;
            overrun_q    <= 1'b0;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                snap_q[k] <= '0;
                vol_q[k]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            ch_q         <= ch_d;
            sum_q        <= sum_d;
            level_q      <= level_d;
            sample_stb_q <= sample_stb_d;
            clip_q       <= clip_d;
            overrun_q    <= overrun_d;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                snap_q[k] <= snap_d[k];
                vol_q[k]  <= vol_d[k];
            end
        end
    end

`ifdef SND_DAC_ORDER2_EN
    localparam int I_W = PCM_W + 4;
    localparam int E_W = PCM_W + 6;
    localparam logic signed [I_W-1:0] I_MAX = {1'b0, {(I_W-1){1'b1}}};
    localparam logic signed [I_W-1:0] I_MIN = ~I_MAX;
    localparam logic signed [E_W-1:0] HALF  = E_W'(2 ** (PCM_W - 1));

    logic signed [I_W-1:0]   i1_q, i1_d, i2_q, i2_d;
    logic signed [PCM_W-1:0] lvl_s;
    logic signed [E_W-1:0]   x_e, fb_e;

    function automatic logic signed [I_W-1:0] sat_i(input logic signed [E_W-1:0] v);
        if (v > E_W'(I_MAX)) begin
            return I_MAX;
        end else if (v < E_W'(I_MIN)) begin
            return I_MIN;
        end
        return v[I_W-1:0];
    endfunction

    // Input is halved to leave headroom for loop stability.
    assign lvl_s = {~level_q[PCM_W-1], level_q[PCM_W-2:0]};
    assign x_e   = E_W'(lvl_s >>> 1);
    assign fb_e  = pdm_q ? HALF : -HALF;

    always_comb begin
        i1_d  = sat_i(E_W'(i1_q) + x_e - fb_e);
        i2_d  = sat_i(E_W'(i2_q) + E_W'(i1_q) - fb_e);
        pdm_d = ~i2_q[I_W-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i1_q  <= '0;
            i2_q  <= '0;
            pdm_q <= 1'b0;
        end else begin
            i1_q  <= i1_d;
            i2_q  <= i2_d;
            pdm_q <= pdm_d;
        end
    end
`else
    logic [PCM_W:0] acc_q, acc_d;

    always_comb begin
        acc_d = {1'b0, acc_q[PCM_W-1:0]} + {1'b0, level_q};
        pdm_d = acc_q[PCM_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            pdm_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            pdm_q <= pdm_d;
        end
    end
`endif

    assign pdm_out    = pdm_q;
    assign sample_stb = sample_stb_q;
    assign clip       = clip_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_snd_dac_mix.sv
// Directed bench for snd_dac_mix (default build, CHANNELS=2, PCM_W=16, VOL_W=7).
module tb_snd_dac_mix;

    logic        clk;
    logic        rst;
    logic        m2;
    logic [31:0] pcm_in;
    logic [13:0] volume;
    logic        mute;
    logic        pdm_out;
    logic        sample_stb;
    logic        clip;
    logic        overrun;

    int unsigned n_vec;
    int unsigned n_err;
    int unsigned stb_cnt;
    int unsigned base;
    int unsigned ones;

    snd_dac_mix #(
        .CHANNELS (2),
        .PCM_W    (16),
        .VOL_W    (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m2         (m2),
        .pcm_in     (pcm_in),
        .volume     (volume),
        .mute       (mute),
        .pdm_out    (pdm_out),
        .sample_stb (sample_stb),
        .clip       (clip),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            stb_cnt <= stb_cnt;
        end else if (sample_stb) begin
            stb_cnt <= stb_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp,
                         input int unsigned slack);
        logic [31:0] diff;
        n_vec++;
        diff = (got > exp) ? (got - exp) : (exp - got);
        if (diff > slack) begin
            n_err++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d) +/-%0d",
                     tag, got, got, exp, exp, slack);
        end
    endtask

    // One clean M2 period; waits (bounded) for the resulting commit.
    task automatic m2_strobe();
        int unsigned b;
        int unsigned w;
        b = stb_cnt;
        m2 = 1'b1;
        repeat (3) @(negedge clk);
        m2 = 1'b0;
        w = 0;
        while (stb_cnt == b && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("stb_one", stb_cnt - b, 1, 0);
    endtask

    task automatic strobes(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) m2_strobe();
    endtask

    task automatic count_ones(input int unsigned n, output int unsigned cnt);
        cnt = 0;
        repeat (3) @(negedge clk);
        repeat (n) begin
            @(negedge clk);
            cnt += pdm_out;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #4ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec   = 0;
        n_err   = 0;
        stb_cnt = 0;
        m2      = 1'b0;
        mute    = 1'b0;
        pcm_in  = '0;
        volume  = '0;
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_pdm", pdm_out, 0, 0);
        check("rst_stb", sample_stb, 0, 0);
        check("rst_clip", clip, 0, 0);
        check("rst_ovr", overrun, 0, 0);
        check("rst_level", dut.level_q, 16'h8000, 0);

        // Zero volume: midscale, density 0.5
        pcm_in = {16'h1234, 16'h4000};
        strobes(20);
        check("v0_level", dut.level_q, 16'h8000, 0);
        check("v0_clip", clip, 0, 0);
        check("v0_ovr", overrun, 0, 0);
        count_ones(4096, ones);
        check("v0_dens", ones, 2048, 1);

        // Ramp from 0 to 127 with ch0 = 0x4000
        pcm_in = {16'h0000, 16'h4000};
        volume = {7'd127, 7'd127};
        base = stb_cnt;
        strobes(126);
        check("ramp126_vol", dut.vol_q[0], 126, 0);
        check("ramp126_lvl", dut.level_q, 16'hBF00, 0);
        m2_strobe();
        check("ramp_stbs", stb_cnt - base, 127, 0);
        check("ramp127_vol", dut.vol_q[0], 127, 0);
        check("ramp127_lvl", dut.level_q, 16'hBF80, 0);
        count_ones(4096, ones);
        check("ramp_dens", ones, 3064, 1);
        m2_strobe();
        check("ramp_hold", dut.vol_q[0], 127, 0);

        // Positive saturation
        pcm_in = {16'h7FFF, 16'h7FFF};
        m2_strobe();
        check("satp_clip", clip, 1, 0);
        check("satp_lvl", dut.level_q, 16'hFFFF, 0);
        count_ones(4096, ones);
        check("satp_dens", ones, 4095, 1);

        // Negative saturation: level 0 never emits a one
        pcm_in = {16'h8000, 16'h8000};
        m2_strobe();
        check("satn_clip", clip, 1, 0);
        check("satn_lvl", dut.level_q, 16'h0000, 0);
        count_ones(4096, ones);
        check("satn_dens", ones, 0, 0);

        pcm_in = {16'h0000, 16'h0000};
        m2_strobe();
        check("zero_clip", clip, 0, 0);
        check("zero_lvl", dut.level_q, 16'h8000, 0);

        // (4660-4096)*127 = 71628; >>>7 = 559 = 0x22F
        pcm_in = {16'hF000, 16'h1234};
        m2_strobe();
        check("mix_lvl", dut.level_q, 16'h822F, 0);
        check("mix_clip", clip, 0, 0);

        // (1-2)*127 = -127; arithmetic >>>7 = -1
        pcm_in = {16'hFFFE, 16'h0001};
        m2_strobe();
        check("neg_lvl", dut.level_q, 16'h7FFF, 0);

        // Mute ramps down one step per strobe
        pcm_in = {16'h0000, 16'h4000};
        mute = 1'b1;
        m2_strobe();
        check("mute1_vol", dut.vol_q[0], 126, 0);
        check("mute1_lvl", dut.level_q, 16'hBF00, 0);
        strobes(126);
        check("mute_vol0", dut.vol_q[0], 0, 0);
        check("mute_lvl", dut.level_q, 16'h8000, 0);
        m2_strobe();
        check("mute_nowrap", dut.vol_q[0], 0, 0);
        count_ones(4096, ones);
        check("mute_dens", ones, 2048, 1);
        mute = 1'b0;

        // Glitch: second falling edge 2 clk after the first
        base = stb_cnt;
        m2 = 1'b1;
        repeat (3) @(negedge clk);
        m2 = 1'b0;
        @(negedge clk);
        m2 = 1'b1;
        @(negedge clk);
        m2 = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_stbs", stb_cnt - base, 1, 0);
        check("glitch_ovr", overrun, 1, 0);
        strobes(3);
        check("ovr_sticky", overrun, 1, 0);
        do_reset();
        check("ovr_clr", overrun, 0, 0);

        // Reset during MAC aborts the sample
        pcm_in = {16'h0000, 16'h4000};
        volume = {7'd127, 7'd127};
        base = stb_cnt;
        m2 = 1'b1;
        repeat (3) @(negedge clk);
        m2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_stbs", stb_cnt - base, 0, 0);
        check("abort_lvl", dut.level_q, 16'h8000, 0);
        check("abort_vol", dut.vol_q[0], 0, 0);
        count_ones(4096, ones);
        check("abort_dens", ones, 2048, 1);

        // Fresh sample after abort uses vol 1: 16384*1 >>> 7 = 128
        m2_strobe();
        check("post_lvl", dut.level_q, 16'h8080, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
